fifo_param: RTL and testbench

Parametrised synchronous FIFO for the virtual-channel buffers of the PCIe QoS datapath. It succeeds the fixed-size FIFO and adds configurable data width and depth, run-time almost-full/almost-empty thresholds, an occupancy count, a registered output valid strobe, and a sticky overflow/underflow error. One instance sits per virtual channel, between the traffic-class mapper and the arbiter.

---
 rtl/fifo_param_pkg.sv | 28 ++
 rtl/fifo_param_dual_port_mem.sv | 53 +++++
 rtl/fifo_param.sv | 115 +++++++++++
 tb/tb_fifo_param.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_param_pkg.sv
// Shared definitions for the per-virtual-channel FIFO: the depth helper, status-vector
// bit positions for the arbiter, and the default almost-full/almost-empty thresholds.
package fifo_param_pkg;

    function automatic int depth_of(input int addr_w);
        return 32'd1 << addr_w;
    endfunction

    localparam int DEF_ADDR_W = 3;
    localparam int AF_TH_DEF  = depth_of(DEF_ADDR_W) - 2;
    localparam int AE_TH_DEF  = 1;

    // Bit positions within the arbiter's per-VC status vector
    localparam int FLAG_FULL_BIT     = 0;
    localparam int FLAG_EMPTY_BIT    = 1;
    localparam int FLAG_AFULL_BIT    = 2;
    localparam int FLAG_AEMPTY_BIT   = 3;
    localparam int FLAG_ERROR_BIT    = 4;
    localparam int FLAG_VEC_W        = 5;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fifo_param_dual_port_mem.sv
// DEPTH x BW storage with one synchronous write port and one synchronous read port
// whose data register is cleared by reset; the array itself is never cleared.
module dual_port_mem
    import fifo_param_pkg::*;
#(
    parameter int BW     = 6,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BW-1:0]     wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [BW-1:0]     rd_data
);

    localparam int DEPTH = depth_of(ADDR_W);

    logic [BW-1:0] mem_q [DEPTH];
    logic [BW-1:0] rd_data_d;
    logic [BW-1:0] rd_data_q;

    // Read register holds its last word unless a read is requested
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Storage write; the read above sees the pre-write word on a same-address collision
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read data register with synchronous clear
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO: pointers, occupancy count, threshold flags and a sticky
// overflow/underflow error around a dual-port memory with registered read data.
module fifo_param
    import fifo_param_pkg::*;
#(
    parameter int BW     = 6,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              fifo_wr,
    input  logic              fifo_rd,
    input  logic [BW-1:0]     fifo_data_in,
    input  logic [ADDR_W:0]   almost_full_th,
    input  logic [ADDR_W:0]   almost_empty_th,
    output logic [BW-1:0]     fifo_data_out,
    output logic              fifo_valid_out,
    output logic [ADDR_W:0]   fifo_count,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              fifo_almost_full,
    output logic              fifo_almost_empty,
    output logic              error_output
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W:0] DEPTH_C = CNT_W'(depth_of(ADDR_W));

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              valid_q, valid_d;
    logic              error_q, error_d;
    logic              rd_acc;
    logic              wr_acc;
    logic              overflow;
    logic              underflow;
    fifo_op_e          op;

    assign fifo_full         = (count_q == DEPTH_C);
    assign fifo_empty        = (count_q == '0);
    assign fifo_almost_full  = (count_q >= almost_full_th);
    assign fifo_almost_empty = (count_q <= almost_empty_th);

    // Acceptance: a write into a full FIFO is fine when a read frees a slot on the same edge
    always_comb begin
        rd_acc    = fifo_rd & ~fifo_empty;
        wr_acc    = fifo_wr & (~fifo_full | rd_acc);
        overflow  = fifo_wr & fifo_full & ~rd_acc;
        underflow = fifo_rd & fifo_empty;
        op        = fifo_op_e'({wr_acc, rd_acc});
    end

    // Next-state for pointers, count, valid strobe and sticky error
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = rd_acc;
        error_d  = error_q | overflow | underflow;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case (op)
            OP_WR:   count_d = count_q + CNT_W'(1);
            OP_RD:   count_d = count_q - CNT_W'(1);
            OP_BOTH: count_d = count_q;
            OP_IDLE: count_d = count_q;
            default: count_d = count_q;
        endcase
    end

    // Control state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    dual_port_mem #(
        .BW     (BW),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .reset_L (reset_L),
        .wr_en   (wr_acc & reset_L),
        .wr_addr (wr_ptr_q),
        .wr_data (fifo_data_in),
        .rd_en   (rd_acc & reset_L),
        .rd_addr (rd_ptr_q),
        .rd_data (fifo_data_out)
    );

    assign fifo_valid_out = valid_q;
    assign fifo_count     = count_q;
    assign error_output   = error_q;

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param (BW=6, ADDR_W=3): fill, full-throughput, overflow,
// drain, underflow, pointer wrap, empty rd/wr collision and mid-stream reset.
module tb_fifo_param;

    localparam int BW     = 6;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              reset_L;
    logic              fifo_wr;
    logic              fifo_rd;
    logic [BW-1:0]     fifo_data_in;
    logic [ADDR_W:0]   almost_full_th;
    logic [ADDR_W:0]   almost_empty_th;
    logic [BW-1:0]     fifo_data_out;
    logic              fifo_valid_out;
    logic [ADDR_W:0]   fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_almost_full;
    logic              fifo_almost_empty;
    logic              error_output;

    int n_cmp = 0;
    int n_err = 0;

    fifo_param #(.BW(BW), .ADDR_W(ADDR_W)) dut (
        .clk               (clk),
        .reset_L           (reset_L),
        .fifo_wr           (fifo_wr),
        .fifo_rd           (fifo_rd),
        .fifo_data_in      (fifo_data_in),
        .almost_full_th    (almost_full_th),
        .almost_empty_th   (almost_empty_th),
        .fifo_data_out     (fifo_data_out),
        .fifo_valid_out    (fifo_valid_out),
        .fifo_count        (fifo_count),
        .fifo_full         (fifo_full),
        .fifo_empty        (fifo_empty),
        .fifo_almost_full  (fifo_almost_full),
        .fifo_almost_empty (fifo_almost_empty),
        .error_output      (error_output)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_data", 32'(fifo_data_out), 32'd0);
        chk("rst_valid", 32'(fifo_valid_out), 32'd0);
        chk("rst_err", 32'(error_output), 32'd0);
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_full", 32'(fifo_full), 32'd0);
        chk("rst_ae", 32'(fifo_almost_empty), 32'd1);
        chk("rst_af", 32'(fifo_almost_full), 32'd0);
    endtask

    logic [BW-1:0] fill_vec [8];
    logic [BW-1:0] drain_exp [8];

    initial begin
        fill_vec  = '{6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h09, 6'h01};
        drain_exp = '{6'h0E, 6'h0F, 6'h09, 6'h01, 6'h15, 6'h15, 6'h15, 6'h15};
        reset_L = 1'b0; fifo_wr = 1'b0; fifo_rd = 1'b0; fifo_data_in = 6'h00;
        almost_full_th = 4'd6; almost_empty_th = 4'd1;
        tick(); tick();
        chk_reset_state();

        // Fill to full with flag tracking
        reset_L = 1'b1;
        for (int i = 0; i < 8; i++) begin
            fifo_wr = 1'b1; fifo_data_in = fill_vec[i];
            tick();
            chk("fill_count", 32'(fifo_count), 32'(i + 1));
            chk("fill_ae", 32'(fifo_almost_empty), (i + 1 <= 1) ? 32'd1 : 32'd0);
            chk("fill_af", 32'(fifo_almost_full), (i + 1 >= 6) ? 32'd1 : 32'd0);
            chk("fill_full", 32'(fifo_full), (i + 1 == 8) ? 32'd1 : 32'd0);
            chk("fill_err", 32'(error_output), 32'd0);
        end

        // Full-throughput simultaneous rd/wr while full
        for (int i = 0; i < 4; i++) begin
            fifo_wr = 1'b1; fifo_rd = 1'b1; fifo_data_in = 6'h15;
            tick();
            chk("both_count", 32'(fifo_count), 32'd8);
            chk("both_data", 32'(fifo_data_out), 32'(fill_vec[i]));
            chk("both_valid", 32'(fifo_valid_out), 32'd1);
            chk("both_err", 32'(error_output), 32'd0);
        end

        // Overflow: dropped, sticky error
        fifo_wr = 1'b1; fifo_rd = 1'b0; fifo_data_in = 6'h3F;
        tick();
        chk("ovf_count", 32'(fifo_count), 32'd8);
        chk("ovf_err", 32'(error_output), 32'd1);
        chk("ovf_valid", 32'(fifo_valid_out), 32'd0);
        chk("ovf_hold", 32'(fifo_data_out), 32'h0D);

        // Drain eight words
        fifo_wr = 1'b0; fifo_rd = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("drain_data", 32'(fifo_data_out), 32'(drain_exp[i]));
            chk("drain_valid", 32'(fifo_valid_out), 32'd1);
            chk("drain_count", 32'(fifo_count), 32'(7 - i));
        end
        chk("drain_empty", 32'(fifo_empty), 32'd1);
        tick();
        chk("udf_valid", 32'(fifo_valid_out), 32'd0);
        chk("udf_hold", 32'(fifo_data_out), 32'h15);
        chk("udf_count", 32'(fifo_count), 32'd0);
        chk("udf_err_sticky", 32'(error_output), 32'd1);
        fifo_rd = 1'b0;

        // Reset clears error; underflow alone sets it
        reset_L = 1'b0;
        tick();
        chk_reset_state();
        reset_L = 1'b1; fifo_rd = 1'b1;
        tick();
        chk("udf_err", 32'(error_output), 32'd1);
        chk("udf_valid0", 32'(fifo_valid_out), 32'd0);
        chk("udf_count0", 32'(fifo_count), 32'd0);
        fifo_rd = 1'b0;

        // Wrap-around: 5 in/out, then 8 in/out across index 7->0
        reset_L = 1'b0;
        tick();
        reset_L = 1'b1;
        for (int i = 0; i < 5; i++) begin
            fifo_wr = 1'b1; fifo_data_in = 6'(i + 1);
            tick();
        end
        fifo_wr = 1'b0; fifo_rd = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("wrap1_data", 32'(fifo_data_out), 32'(i + 1));
        end
        fifo_rd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            fifo_wr = 1'b1; fifo_data_in = 6'(32 + i);
            tick();
        end
        fifo_wr = 1'b0;
        chk("wrap_full", 32'(fifo_full), 32'd1);
        chk("wrap_wrptr", 32'(dut.wr_ptr_q), 32'd5);
        chk("wrap_rdptr", 32'(dut.rd_ptr_q), 32'd5);
        fifo_rd = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("wrap2_data", 32'(fifo_data_out), 32'(32 + i));
        end
        fifo_rd = 1'b0;
        chk("wrap_empty", 32'(fifo_empty), 32'd1);
        chk("wrap_err", 32'(error_output), 32'd0);

        // Empty with simultaneous rd/wr: write lands, read is an underflow
        fifo_wr = 1'b1; fifo_rd = 1'b1; fifo_data_in = 6'h22;
        tick();
        chk("ewr_count", 32'(fifo_count), 32'd1);
        chk("ewr_err", 32'(error_output), 32'd1);
        chk("ewr_valid", 32'(fifo_valid_out), 32'd0);
        fifo_wr = 1'b0;
        tick();
        chk("ewr_data", 32'(fifo_data_out), 32'h22);
        chk("ewr_valid2", 32'(fifo_valid_out), 32'd1);
        chk("ewr_count2", 32'(fifo_count), 32'd0);
        fifo_rd = 1'b0;
        tick();
        chk("valid_drop", 32'(fifo_valid_out), 32'd0);
        chk("data_hold", 32'(fifo_data_out), 32'h22);

        // Mid-stream reset at count 4 with requests that must be ignored
        for (int i = 0; i < 4; i++) begin
            fifo_wr = 1'b1; fifo_data_in = 6'(48 + i);
            tick();
        end
        chk("pre_rst_count", 32'(fifo_count), 32'd4);
        reset_L = 1'b0; fifo_wr = 1'b1; fifo_rd = 1'b1; fifo_data_in = 6'h3F;
        tick();
        chk_reset_state();
        reset_L = 1'b1; fifo_rd = 1'b0; fifo_data_in = 6'h2A;
        tick();
        chk("post_rst_count", 32'(fifo_count), 32'd1);
        fifo_wr = 1'b0; fifo_rd = 1'b1;
        tick();
        chk("post_rst_data", 32'(fifo_data_out), 32'h2A);
        chk("post_rst_valid", 32'(fifo_valid_out), 32'd1);
        fifo_rd = 1'b0;

        // Thresholds act combinationally
        almost_full_th = 4'd0;
        #1;
        chk("th_af_zero", 32'(fifo_almost_full), 32'd1);
        almost_empty_th = 4'd0;
        #1;
        chk("th_ae_zero", 32'(fifo_almost_empty), 32'd1);
        almost_full_th = 4'd6; almost_empty_th = 4'd1;
        #1;
        chk("th_af_restore", 32'(fifo_almost_full), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
